// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared sequencer states and brainfuck opcode constants
package bf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TERM  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } bf_state_e;

    localparam logic [7:0] BF_OP_HALT  = 8'h00;
    localparam logic [7:0] BF_OP_INC   = 8'h2B;
    localparam logic [7:0] BF_OP_DEC   = 8'h2D;
    localparam logic [7:0] BF_OP_LEFT  = 8'h3C;
    localparam logic [7:0] BF_OP_RIGHT = 8'h3E;
    localparam logic [7:0] BF_OP_OUT   = 8'h2E;
    localparam logic [7:0] BF_OP_IN    = 8'h2C;
    localparam logic [7:0] BF_OP_JZ    = 8'h5B;
    localparam logic [7:0] BF_OP_JNZ   = 8'h5D;

    function automatic logic [7:0] bf_op_by_index(input logic [2:0] idx);
        logic [7:0] op;
        op = BF_OP_HALT;
        case (idx)
            3'd0: op = BF_OP_INC;
            3'd1: op = BF_OP_DEC;
            3'd2: op = BF_OP_LEFT;
            3'd3: op = BF_OP_RIGHT;
            3'd4: op = BF_OP_OUT;
            3'd5: op = BF_OP_IN;
            3'd6: op = BF_OP_JZ;
            3'd7: op = BF_OP_JNZ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bf_run_ctrl_if.sv
// rtl/bf_run_ctrl_if.sv - program byte stream plus program/data RAM write ports of the run sequencer
interface bf_run_ctrl_if #(
    parameter int ADDR_W = 8
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] pmem_addr;
    logic [7:0]        pmem_wdata;
    logic              pmem_wen;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_wen;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, pmem_addr, pmem_wdata, pmem_wen, dmem_addr, dmem_wen
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, pmem_addr, pmem_wdata, pmem_wen, dmem_addr, dmem_wen
    );

endinterface

// File: rtl/bf_halt_detect.sv
// rtl/bf_halt_detect.sv - flags a halted core after HALT_IDLE consecutive cycles without a program fetch
module bf_halt_detect #(
    parameter int HALT_IDLE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic core_prog_ren,
    output logic halted
);

    localparam int                CNT_W = $clog2(HALT_IDLE + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HALT_IDLE);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Saturates at LIMIT so a long-halted core never wraps back to "running".
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!enable || core_prog_ren) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != LIMIT) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign halted = enable && (idle_cnt_q == LIMIT);

endmodule

// File: rtl/bf_run_ctrl.sv
// rtl/bf_run_ctrl.sv - run sequencer: load program, write terminator, clear data RAM, run and re-park core; BF_WATCHDOG_EN adds a run watchdog
module bf_run_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int HALT_IDLE = 8,
    parameter int WDOG_W    = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_start,
    input  logic         abort,
    bf_run_ctrl_if.slave bus,
    output logic         mem_owner,
    output logic         core_reset,
    input  logic         core_prog_ren,
    output logic         busy,
    output logic         done,
    output logic         err_ovf,
    output logic         err_wdog
);

    // Program bytes occupy 0..DEPTH-3; the terminator then always lands at or below DEPTH-2.
    localparam logic [ADDR_W-1:0] LAST_PROG_IDX = ADDR_W'(2**ADDR_W - 3);

    bf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
    logic [7:0]        pmem_wdata_q, pmem_wdata_d;
    logic              pmem_wen_q, pmem_wen_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic              mem_owner_q, mem_owner_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              accept;
    logic              run_end;
    logic              run_en;
    logic              halted;
`ifdef BF_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_wdog_q, err_wdog_d;
`endif

    assign run_en = (state_q == ST_RUN);

    bf_halt_detect #(
        .HALT_IDLE (HALT_IDLE)
    ) u_halt_detect (
        .clk           (clk),
        .reset         (reset),
        .enable        (run_en),
        .core_prog_ren (core_prog_ren),
        .halted        (halted)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_ready_d   = in_ready_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        pmem_wen_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wen_d   = 1'b0;
        mem_owner_d  = mem_owner_q;
        core_reset_d = core_reset_q;
        done_d       = 1'b0;
        err_ovf_d    = err_ovf_q;
        accept       = bus.in_valid && in_ready_q;
        run_end      = 1'b0;
`ifdef BF_WATCHDOG_EN
        wdog_d       = wdog_q;
        err_wdog_d   = err_wdog_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    err_ovf_d  = 1'b0;
`ifdef BF_WATCHDOG_EN
                    err_wdog_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    pmem_wen_d   = 1'b1;
                    pmem_addr_d  = cnt_q;
                    pmem_wdata_d = bus.in_data;
                    cnt_d        = cnt_q + 1'b1;
                    if (bus.in_last) begin
                        state_d    = ST_TERM;
                        in_ready_d = 1'b0;
                    end else if (cnt_q == LAST_PROG_IDX) begin
                        state_d    = ST_TERM;
                        in_ready_d = 1'b0;
                        err_ovf_d  = 1'b1;
                    end
                end
            end
            ST_TERM: begin
                pmem_wen_d   = 1'b1;
                pmem_addr_d  = cnt_q;
                pmem_wdata_d = BF_OP_HALT;
                dmem_wen_d   = 1'b1;
                dmem_addr_d  = '0;
                state_d      = ST_CLEAR;
            end
            ST_CLEAR: begin
                // The address wraps back to 0 on the final step, leaving the port parked at 0.
                dmem_addr_d = dmem_addr_q + 1'b1;
                if (dmem_addr_q == '1) begin
                    state_d      = ST_RUN;
                    mem_owner_d  = 1'b0;
                    core_reset_d = 1'b0;
`ifdef BF_WATCHDOG_EN
                    wdog_d       = '0;
`endif
                end else begin
                    dmem_wen_d = 1'b1;
                end
            end
            ST_RUN: begin
                run_end = halted;
`ifdef BF_WATCHDOG_EN
                wdog_d = wdog_q + 1'b1;
                if (&wdog_d) begin
                    run_end    = 1'b1;
                    err_wdog_d = 1'b1;
                end
`endif
                if (run_end) begin
                    state_d      = ST_DONE;
                    core_reset_d = 1'b1;
                    mem_owner_d  = 1'b1;
                    done_d       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            core_reset_d = 1'b1;
            mem_owner_d  = 1'b1;
            pmem_wen_d   = 1'b0;
            dmem_wen_d   = 1'b0;
            in_ready_d   = 1'b0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            pmem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wen_q   <= 1'b0;
            mem_owner_q  <= 1'b1;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            pmem_wen_q   <= pmem_wen_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            mem_owner_q  <= mem_owner_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

`ifdef BF_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q     <= '0;
            err_wdog_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            err_wdog_q <= err_wdog_d;
        end
    end

    assign err_wdog = err_wdog_q;
`else
    // No watchdog is built; this is constant low for every usable WDOG_W.
    assign err_wdog = (WDOG_W == 0);
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.pmem_addr  = pmem_addr_q;
    assign bus.pmem_wdata = pmem_wdata_q;
    assign bus.pmem_wen   = pmem_wen_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wen   = dmem_wen_q;
    assign mem_owner      = mem_owner_q;
    assign core_reset     = core_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_bf_run_ctrl.sv
// tb/tb_bf_run_ctrl.sv - randomized self-checking bench for bf_run_ctrl; BF_WATCHDOG_EN selects the watchdog expectations
`timescale 1ns/1ps
module tb_bf_run_ctrl;
    import bf_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int HALT_IDLE = 8;
    localparam int WDOG_W    = 6;
    localparam int DEPTH     = 2**ADDR_W;
    localparam int MAX_PROG  = DEPTH - 2;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_start = 1'b0;
    logic abort = 1'b0;
    logic core_prog_ren = 1'b0;
    logic mem_owner, core_reset, busy, done, err_ovf, err_wdog;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+7:0] pm_got[$];
    logic [ADDR_W+7:0] pm_exp[$];
    bit exp_ovf = 1'b0;
    int dm_cnt = 0;
    int dm_bad = 0;
    int dm_next = 0;
    bit core_active = 1'b0;
    int ph = 0;

    bf_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    bf_run_ctrl #(
        .ADDR_W    (ADDR_W),
        .HALT_IDLE (HALT_IDLE),
        .WDOG_W    (WDOG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .abort         (abort),
        .bus           (bus),
        .mem_owner     (mem_owner),
        .core_reset    (core_reset),
        .core_prog_ren (core_prog_ren),
        .busy          (busy),
        .done          (done),
        .err_ovf       (err_ovf),
        .err_wdog      (err_wdog)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM write monitor
    initial forever begin
        @(negedge clk);
        if (bus.pmem_wen === 1'b1) pm_got.push_back({bus.pmem_addr, bus.pmem_wdata});
        if (bus.dmem_wen === 1'b1) begin
            if (bus.dmem_addr !== ADDR_W'(dm_next)) dm_bad++;
            dm_next++;
            dm_cnt++;
        end
    end

    // Core model: one program fetch every 4 cycles while released and active
    initial forever begin
        @(posedge clk);
        #1;
        if (core_reset === 1'b0 && core_active) begin
            ph++;
            core_prog_ren = (ph % 4 == 0);
        end else begin
            ph = 0;
            core_prog_ren = 1'b0;
        end
    end

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        pm_got.delete();
        pm_exp.delete();
        exp_ovf = 1'b0;
        dm_cnt = 0;
        dm_bad = 0;
        dm_next = 0;
        core_active = 1'b1;
    endtask

    task automatic send_prog(input bq_t prog, input bit with_last, input int period);
        int i = 0;
        int slot = 0;
        int taken = 0;
        bit closed = 1'b0;
        bit v;
        while (i < prog.size()) begin
            v = (slot % period == 0);
            bus.in_valid = v;
            bus.in_data = v ? prog[i] : 8'($urandom);
            bus.in_last = v && with_last && (i == prog.size() - 1);
            if (v) begin
                check_eq("in_ready", bus.in_ready, !closed);
                if (!closed) begin
                    pm_exp.push_back({ADDR_W'(taken), prog[i]});
                    taken++;
                    if (bus.in_last || taken == MAX_PROG) begin
                        closed = 1'b1;
                        exp_ovf = !bus.in_last;
                    end
                end
                i++;
            end
            slot++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        if (closed) pm_exp.push_back({ADDR_W'(taken), BF_OP_HALT});
    endtask

    task automatic wait_core_run();
        int n = 0;
        while (core_reset !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("run_reached", n < 1000, 1);
    endtask

    task automatic verify_load();
        check_eq("pm_count", pm_got.size(), pm_exp.size());
        for (int k = 0; k < pm_exp.size() && k < pm_got.size(); k++)
            check_eq("pm_write", pm_got[k], pm_exp[k]);
        check_eq("err_ovf", err_ovf, exp_ovf);
        check_eq("dm_count", dm_cnt, DEPTH);
        check_eq("dm_order", dm_bad, 0);
        check_eq("mem_owner_run", mem_owner, 0);
        check_eq("busy_run", busy, 1);
    endtask

    task automatic halt_and_check();
        int n;
        repeat ($urandom_range(5, 30)) @(negedge clk);
        n = 0;
        while (core_prog_ren !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        core_active = 1'b0;
        // last high fetch is sampled on the next edge; done follows HALT_IDLE+1 edges after that
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("halt_latency", n, HALT_IDLE + 2);
        check_eq("core_reset_done", core_reset, 1);
        check_eq("mem_owner_done", mem_owner, 1);
        check_eq("busy_done", busy, 0);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
    endtask

    function automatic bq_t rand_prog(input int len);
        bq_t q;
        for (int k = 0; k < len; k++) q.push_back(bf_op_by_index(3'($urandom_range(0, 7))));
        return q;
    endfunction

    initial begin
        bq_t prog;
        int n;
        int rc;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_core_reset", core_reset, 1);
        check_eq("rst_mem_owner", mem_owner, 1);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_pmem_wen", bus.pmem_wen, 0);
        check_eq("rst_dmem_wen", bus.dmem_wen, 0);
        check_eq("rst_pmem_addr", bus.pmem_addr, 0);
        check_eq("rst_dmem_addr", bus.dmem_addr, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err_ovf", err_ovf, 0);
        check_eq("rst_err_wdog", err_wdog, 0);

        // "+." then halt
        prog = '{BF_OP_INC, BF_OP_OUT};
        start_load();
        send_prog(prog, 1'b1, 1);
        wait_core_run();
        verify_load();
        halt_and_check();

        // overflow: 300 bytes without in_last
        prog.delete();
        for (int k = 0; k < 300; k++) prog.push_back(8'($urandom));
        start_load();
        send_prog(prog, 1'b0, 1);
        wait_core_run();
        verify_load();
        halt_and_check();

        // valid every 3rd cycle, load_start ignored during RUN
        prog = rand_prog($urandom_range(5, 20));
        start_load();
        send_prog(prog, 1'b1, 3);
        wait_core_run();
        verify_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        check_eq("ign_busy", busy, 1);
        check_eq("ign_core_reset", core_reset, 0);
        check_eq("ign_in_ready", bus.in_ready, 0);
        check_eq("ign_pm_count", pm_got.size(), pm_exp.size());
        halt_and_check();

        // abort midway through CLEAR
        prog = rand_prog($urandom_range(3, 10));
        start_load();
        send_prog(prog, 1'b1, 1);
        n = 0;
        while (dm_cnt < DEPTH / 2 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq("clear_reached", dm_cnt >= DEPTH / 2, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_dmem_wen", bus.dmem_wen, 0);
        check_eq("abort_core_reset", core_reset, 1);
        check_eq("abort_mem_owner", mem_owner, 1);
        @(negedge clk);
        check_eq("abort_partial", dm_cnt < DEPTH, 1);
        abort = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
        check_eq("abort_wins_busy", busy, 0);
        check_eq("abort_wins_ready", bus.in_ready, 0);
        start_load();
        check_eq("reload_in_ready", bus.in_ready, 1);
        check_eq("reload_busy", busy, 1);
        send_prog(rand_prog($urandom_range(3, 10)), 1'b1, 1);
        wait_core_run();
        verify_load();
        halt_and_check();

        // core never halts
        start_load();
        send_prog(rand_prog(4), 1'b1, 1);
        wait_core_run();
`ifdef BF_WATCHDOG_EN
        rc = 0;
        while (core_reset === 1'b0 && rc < 500) begin
            rc++;
            @(negedge clk);
        end
        check_eq("wdog_run_cycles", rc, 2**WDOG_W - 1);
        check_eq("wdog_done", done, 1);
        check_eq("wdog_err", err_wdog, 1);
        core_active = 1'b0;
`else
        rc = 0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1) rc++;
        end
        check_eq("nowdog_done", rc, 0);
        check_eq("nowdog_busy", busy, 1);
        check_eq("nowdog_err", err_wdog, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        core_active = 1'b0;
`endif

        start_load();
        check_eq("clr_err_wdog", err_wdog, 0);
        check_eq("clr_err_ovf", err_ovf, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check_eq("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
